// File: rtl/lfsr_pulse_emitter_pkg.sv
// Shared encodings and default sizes for the lighthouse LFSR emitter and
// the receive-side blocks that reuse the same LFSR step.
package lfsr_pulse_emitter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } emit_state_t;

  localparam int DEF_TICKS_PER_BIT = 16;
  localparam int DEF_LFSR_WIDTH    = 17;
  localparam int TS_WIDTH          = 24;

  function automatic logic lfsr_parity(
    input logic [DEF_LFSR_WIDTH-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr_pulse_emitter_lfsr_step.sv
// One Fibonacci LFSR step: output chip is parity of the tapped bits,
// which is shifted in at the bottom. Shared with the receive-side finders.
module lfsr_step #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] polynomial,
  output logic             chip,
  output logic [WIDTH-1:0] next_state
);

  assign chip       = ^(state & polynomial);
  assign next_state = {state[WIDTH-2:0], chip};

endmodule

// File: rtl/lfsr_pulse_emitter.sv
// BMC-encoded LFSR burst emitter. Define LFSR_EMITTER_TS_EN to capture
// sys_ts at the first bit-cell edge on ts_start; otherwise ts_start is 0.
module lfsr_pulse_emitter
  import lfsr_pulse_emitter_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int LFSR_WIDTH    = DEF_LFSR_WIDTH
) (
  input  logic                  clk_96MHz,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LFSR_WIDTH-1:0] polynomial,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [LFSR_WIDTH-1:0] pulse_length,
  input  logic [TS_WIDTH-1:0]   sys_ts,
  output logic                  bmc_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LFSR_WIDTH-1:0] lfsr_state,
  output logic [TS_WIDTH-1:0]   ts_start
);

  localparam int TW =
    (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICKS_PER_BIT / 2 - 1);
  localparam logic [LFSR_WIDTH-1:0] CNT_ONE = LFSR_WIDTH'(1);

  emit_state_t           state_q;
  logic [LFSR_WIDTH-1:0] poly_q;
  logic [LFSR_WIDTH-1:0] cnt_q;
  logic [TW-1:0]         tick_q;
  logic                  chip;
  logic [LFSR_WIDTH-1:0] next_state;
  logic                  load_ok;

  lfsr_step #(
    .WIDTH(LFSR_WIDTH)
  ) u_step (
    .state     (lfsr_state),
    .polynomial(poly_q),
    .chip      (chip),
    .next_state(next_state)
  );

  // All-zero taps, seed or length cannot produce a meaningful burst.
  assign load_ok = (poly_q != '0)
                && (lfsr_state != '0)
                && (cnt_q != '0);

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      poly_q     <= '0;
      cnt_q      <= '0;
      tick_q     <= '0;
      lfsr_state <= '0;
      bmc_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            poly_q     <= polynomial;
            lfsr_state <= seed;
            cnt_q      <= pulse_length;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (!load_ok) begin
            error   <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= EMIT;
            busy    <= 1'b1;
            bmc_out <= ~bmc_out;
            tick_q  <= '0;
          end
        end
        EMIT: begin
          if (tick_q == TICK_LAST) begin
            lfsr_state <= next_state;
            cnt_q      <= cnt_q - CNT_ONE;
            tick_q     <= '0;
            if (cnt_q == CNT_ONE) begin
              state_q <= FINISH;
              bmc_out <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              bmc_out <= ~bmc_out;
            end
          end else begin
            tick_q <= tick_q + TICK_ONE;
            // Mid-cell transition encodes a one.
            if (chip && tick_q == TICK_PRE) begin
              bmc_out <= ~bmc_out;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LFSR_EMITTER_TS_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else if (state_q == LOAD && load_ok) begin
      ts_q <= sys_ts;
    end
  end

  assign ts_start = ts_q;
`else
  logic unused_ts;

  assign unused_ts = ^sys_ts;
  assign ts_start  = '0;
`endif

endmodule

// File: tb/tb_lfsr_pulse_emitter.sv
// Directed bench for lfsr_pulse_emitter: waveform, errors, held start,
// async abort, and long-count/timestamp behaviour.
module tb_lfsr_pulse_emitter;

  logic        clk_96MHz = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [16:0] polynomial = '0;
  logic [16:0] seed = '0;
  logic [16:0] pulse_length = '0;
  logic [23:0] sys_ts = '0;
  logic        bmc_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [16:0] lfsr_state;
  logic [23:0] ts_start;

  int checks = 0;
  int failures = 0;

  always #5 clk_96MHz = ~clk_96MHz;

  lfsr_pulse_emitter dut (
    .clk_96MHz   (clk_96MHz),
    .reset_n     (reset_n),
    .start       (start),
    .polynomial  (polynomial),
    .seed        (seed),
    .pulse_length(pulse_length),
    .sys_ts      (sys_ts),
    .bmc_out     (bmc_out),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .lfsr_state  (lfsr_state),
    .ts_start    (ts_start)
  );

  task automatic tick();
    @(posedge clk_96MHz);
    #1;
  endtask

  task automatic kick(input logic [16:0] p,
                      input logic [16:0] s,
                      input logic [16:0] n);
    polynomial   = p;
    seed         = s;
    pulse_length = n;
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Hand-derived envelope for poly 0x1D258, seed 1: bits 0,0,0,1.
  function automatic logic basic_bmc(input int i);
    return (i < 16) || (i >= 32 && i < 48) || (i >= 56 && i < 64);
  endfunction

  task automatic test_reset();
    #2 reset_n = 1'b0;
    tick();
    tick();
    checks += 6;
    if (bmc_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_bmc got=%b exp=0", bmc_out);
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL reset_error got=%b exp=0", error);
    end
    if (lfsr_state !== 17'h0) begin
      failures++;
      $display("FAIL reset_lfsr got=%h exp=0", lfsr_state);
    end
    if (ts_start !== 24'h0) begin
      failures++;
      $display("FAIL reset_ts got=%h exp=0", ts_start);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n_done = 0;
    int n_err = 0;
    logic [23:0] exp_ts;
`ifdef LFSR_EMITTER_TS_EN
    exp_ts = 24'h000123;
`else
    exp_ts = 24'h0;
`endif
    sys_ts = 24'h000123;
    kick(17'h1D258, 17'h00001, 17'd4);
    checks++;
    if (bmc_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_load bmc=%b busy=%b exp=0/0", bmc_out, busy);
    end
    for (int i = 0; i < 66; i++) begin
      tick();
      if (done) n_done++;
      if (error) n_err++;
      checks += 2;
      if (bmc_out !== basic_bmc(i)) begin
        failures++;
        $display("FAIL basic_bmc[%0d] got=%b exp=%b", i, bmc_out, basic_bmc(i));
      end
      if (busy !== (i < 64)) begin
        failures++;
        $display("FAIL basic_busy[%0d] got=%b exp=%b", i, busy, (i < 64));
      end
      if (i == 0) begin
        checks++;
        if (ts_start !== exp_ts) begin
          failures++;
          $display("FAIL basic_ts got=%h exp=%h", ts_start, exp_ts);
        end
        sys_ts = 24'h000999;
      end
      if (i == 16 || i == 32 || i == 48) begin
        logic [16:0] e;
        e = (i == 16) ? 17'h2 : (i == 32) ? 17'h4 : 17'h8;
        checks++;
        if (lfsr_state !== e) begin
          failures++;
          $display("FAIL basic_lfsr[%0d] got=%h exp=%h", i, lfsr_state, e);
        end
      end
      if (i == 64) begin
        checks++;
        if (done !== 1'b1 || lfsr_state !== 17'h00011) begin
          failures++;
          $display("FAIL basic_done done=%b lfsr=%h exp=1/00011", done, lfsr_state);
        end
      end
    end
    checks += 2;
    if (n_done != 1) begin
      failures++;
      $display("FAIL basic_done_count got=%0d exp=1", n_done);
    end
    if (n_err != 0) begin
      failures++;
      $display("FAIL basic_err_count got=%0d exp=0", n_err);
    end
    repeat (10) tick();
    checks += 2;
    if (lfsr_state !== 17'h00011) begin
      failures++;
      $display("FAIL basic_hold got=%h exp=00011", lfsr_state);
    end
    if (ts_start !== exp_ts) begin
      failures++;
      $display("FAIL basic_ts_hold got=%h exp=%h", ts_start, exp_ts);
    end
  endtask

  task automatic test_single_bit();
    int n_done = 0;
    kick(17'h1D258, 17'h00001, 17'd1);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (done) n_done++;
      checks++;
      if (bmc_out !== (i < 16)) begin
        failures++;
        $display("FAIL single_bmc[%0d] got=%b exp=%b", i, bmc_out, (i < 16));
      end
      if (i == 16) begin
        checks++;
        if (done !== 1'b1 || lfsr_state !== 17'h2) begin
          failures++;
          $display("FAIL single_end done=%b lfsr=%h exp=1/00002", done, lfsr_state);
        end
      end
    end
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL single_done_count got=%0d exp=1", n_done);
    end
  endtask

  task automatic test_errors();
    logic [16:0] p [3] = '{17'h0, 17'h1D258, 17'h1D258};
    logic [16:0] s [3] = '{17'h1, 17'h0, 17'h1};
    logic [16:0] n [3] = '{17'd4, 17'd4, 17'd0};
    for (int v = 0; v < 3; v++) begin
      kick(p[v], s[v], n[v]);
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL err%0d_load error=%b busy=%b exp=0/0", v, error, busy);
      end
      tick();
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || bmc_out !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL err%0d_pulse error=%b busy=%b bmc=%b done=%b exp=1/0/0/0",
                 v, error, busy, bmc_out, done);
      end
      tick();
      checks++;
      if (error !== 1'b0 || busy !== 1'b0 || bmc_out !== 1'b0) begin
        failures++;
        $display("FAIL err%0d_after error=%b busy=%b bmc=%b exp=0/0/0",
                 v, error, busy, bmc_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    logic eb;
    polynomial   = 17'h1D258;
    seed         = 17'h00001;
    pulse_length = 17'd4;
    start        = 1'b1;
    tick();
    for (int i = 0; i < 68; i++) begin
      tick();
      if (done) n_done++;
      eb = (i < 64) ? basic_bmc(i) : (i == 67);
      checks += 2;
      if (bmc_out !== eb) begin
        failures++;
        $display("FAIL b2b_bmc[%0d] got=%b exp=%b", i, bmc_out, eb);
      end
      if (busy !== (i < 64 || i == 67)) begin
        failures++;
        $display("FAIL b2b_busy[%0d] got=%b exp=%b", i, busy, (i < 64 || i == 67));
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 1) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=1", n_done);
    end
    do_reset();
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    kick(17'h1D258, 17'h00001, 17'd4);
    repeat (40) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bmc_out !== 1'b0 || busy !== 1'b0 || lfsr_state !== 17'h0) begin
      failures++;
      $display("FAIL abort_async bmc=%b busy=%b lfsr=%h exp=0/0/0",
               bmc_out, busy, lfsr_state);
    end
    tick();
    if (done) n_done++;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy || bmc_out) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      failures++;
      $display("FAIL abort_quiet activity=%0d exp=0", n_done);
    end
  endtask

  task automatic test_long_count();
    int n_done = 0;
    logic [23:0] exp_ts;
`ifdef LFSR_EMITTER_TS_EN
    exp_ts = 24'hFFFFF0;
`else
    exp_ts = 24'h0;
`endif
    sys_ts = 24'hFFFFF0;
    kick(17'h1D258, 17'h00001, 17'h1FFFF);
    tick();
    checks += 2;
    if (bmc_out !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL long_first bmc=%b busy=%b exp=1/1", bmc_out, busy);
    end
    if (ts_start !== exp_ts) begin
      failures++;
      $display("FAIL long_ts got=%h exp=%h", ts_start, exp_ts);
    end
    sys_ts = 24'h000005;
    repeat (3000) begin
      tick();
      if (done) n_done++;
    end
    checks += 3;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL long_busy got=%b exp=1", busy);
    end
    if (n_done != 0) begin
      failures++;
      $display("FAIL long_early_done got=%0d exp=0", n_done);
    end
    if (ts_start !== exp_ts) begin
      failures++;
      $display("FAIL long_ts_hold got=%h exp=%h", ts_start, exp_ts);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_bit();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_long_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
